// File: rtl/nf10_barrier_sched_pkg.sv
// nf10_barrier_pkg: shared state encoding and requester-count helper for the barrier scheduler
package nf10_barrier_pkg;
  typedef enum logic [1:0] {BAR_IDLE, BAR_GATHER, BAR_RELEASE, BAR_ERROR} bar_state_t;
  function automatic int nreq(input int num_ports);
    return num_ports + 2;
  endfunction
endpackage

// File: rtl/nf10_barrier_sched_if.sv
// nf10_barrier_sched_if: activity, barrier request and status signals of the barrier scheduler
interface nf10_barrier_sched_if #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W = 16
);
  import nf10_barrier_pkg::*;
  localparam int NREQ = nreq(NUM_PORTS);
  logic [NUM_PORTS:0] activity_stim;
  logic [NUM_PORTS:0] activity_rec;
  logic [NUM_PORTS:0] barrier_req;
  logic activity_trans_sim;
  logic activity_trans_log;
  logic barrier_req_trans;
  logic err_clear;
  logic barrier_proceed;
  logic timeout_err;
  logic [NREQ-1:0] missing_mask;
  logic [CNT_W-1:0] barrier_count;
  modport master(
    output activity_stim, activity_rec, activity_trans_sim, activity_trans_log,
    output barrier_req, barrier_req_trans, err_clear,
    input barrier_proceed, timeout_err, missing_mask, barrier_count
  );
  modport slave(
    input activity_stim, activity_rec, activity_trans_sim, activity_trans_log,
    input barrier_req, barrier_req_trans, err_clear,
    output barrier_proceed, timeout_err, missing_mask, barrier_count
  );
endinterface

// File: rtl/nf10_barrier_sched_idle_timer.sv
// nf10_barrier_idle_timer: saturating idle counter, expire flags the last tolerated idle cycle
module nf10_barrier_idle_timer #(
  parameter int INACTIVITY_TIMEOUT = 1500
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expire
);
  localparam int W = $clog2(INACTIVITY_TIMEOUT);
  localparam logic [W-1:0] LAST = W'(INACTIVITY_TIMEOUT - 1);
  logic [W-1:0] count;
  assign expire = count == LAST;
  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (tick && !expire) count <= count + 1'b1;
  end
endmodule

// File: rtl/nf10_barrier_sched.sv
// nf10_barrier_sched: global barrier release once every requester waits, with inactivity timeout
module nf10_barrier_sched
  import nf10_barrier_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int INACTIVITY_TIMEOUT = 1500,
  parameter int CNT_W = 16
) (
  input logic axi_aclk,
  input logic axi_reset,
  nf10_barrier_sched_if.slave bus
);
  localparam int NREQ = nreq(NUM_PORTS);
  bar_state_t state;
  logic [NREQ-1:0] r;
  logic [NREQ-1:0] a;
  logic all_req;
  logic no_req;
  logic quiet;
  logic clear;
  logic expire;
  assign r = {bus.barrier_req, bus.barrier_req_trans};
  assign a = {bus.activity_stim | bus.activity_rec, bus.activity_trans_sim | bus.activity_trans_log};
  always_comb begin
    all_req = &r;
    no_req = ~|r;
    quiet = ~|a;
    clear = state != BAR_GATHER || !quiet;
  end
  // The idle count only advances while gathering with no activity anywhere
  nf10_barrier_idle_timer #(.INACTIVITY_TIMEOUT(INACTIVITY_TIMEOUT)) u_timer (
    .clk(axi_aclk),
    .rst(axi_reset),
    .clear(clear),
    .tick(!clear),
    .expire(expire)
  );
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state <= BAR_IDLE;
      bus.barrier_proceed <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.missing_mask <= '0;
      bus.barrier_count <= '0;
    end else begin
      case (state)
        BAR_IDLE:
          if (all_req) begin
            state <= BAR_RELEASE;
            bus.barrier_proceed <= 1'b1;
          end else if (!no_req) state <= BAR_GATHER;
        BAR_GATHER:
          if (all_req) begin
            state <= BAR_RELEASE;
            bus.barrier_proceed <= 1'b1;
          end else if (no_req) state <= BAR_IDLE;
          else if (expire && quiet) begin
            state <= BAR_ERROR;
            bus.timeout_err <= 1'b1;
            bus.missing_mask <= ~r;
          end
        BAR_RELEASE:
          if (no_req) begin
            state <= BAR_IDLE;
            bus.barrier_proceed <= 1'b0;
            bus.barrier_count <= bus.barrier_count + 1'b1;
          end
        BAR_ERROR:
          if (bus.err_clear) begin
            state <= BAR_IDLE;
            bus.timeout_err <= 1'b0;
            bus.missing_mask <= '0;
          end
        default: state <= BAR_IDLE;
      endcase
    end
  end
endmodule
